alu_issue_stage: RTL and testbench

ID/EX pipeline register and operand-select front end sitting directly upstream of the 32-bit ALU in the pipelined MIPS core. Captures decoded instruction fields each cycle, generates the 4-bit ALU control from ALUOp/funct, and resolves data hazards by forwarding from EX/MEM and MEM/WB. Drives the ALU's A, B and control inputs.

---
 rtl/mips_pkg.sv | 45 ++++
 rtl/alu_ctrl_decode.sv | 36 +++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 tb/tb_alu_issue_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, ALUOp codes, funct values, ID/EX control bundle.
package mips_pkg;

  localparam int unsigned WIDTH      = 32;
  localparam int unsigned RADDR      = 5;
  localparam int unsigned ALU_CTRL_W = 4;
  localparam int unsigned ALU_OP_W   = 2;
  localparam int unsigned FUNCT_W    = 6;

  // ALU control codes driven into the 32-bit ALU
  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

  // ALUOp field produced by the main decoder
  typedef enum logic [ALU_OP_W-1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_RSVD  = 2'b11
  } alu_op_e;

  // Supported R-type funct encodings
  localparam logic [FUNCT_W-1:0] FUNCT_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] FUNCT_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] FUNCT_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] FUNCT_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] FUNCT_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] FUNCT_NOR = 6'b100111;

  // Control portion of the ID/EX register; all-zero is a bubble
  typedef struct packed {
    logic                valid;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                alu_src;
    logic [ALU_OP_W-1:0] alu_op;
    logic [FUNCT_W-1:0]  funct;
  } idex_ctrl_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALUOp/funct to ALU control decoder; purely combinational, shared with the single-cycle core.
module alu_ctrl_decode
  import mips_pkg::*;
(
  input  logic [ALU_OP_W-1:0]   alu_op,
  input  logic [FUNCT_W-1:0]    funct,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal
);

  // Reserved ALUOp and unknown funct both fall back to add; only R-type flags illegal
  always_comb begin
    alu_control = ALU_ADD;
    illegal     = 1'b0;
    case (alu_op_e'(alu_op))
      ALUOP_ADD:  alu_control = ALU_ADD;
      ALUOP_SUB:  alu_control = ALU_SUB;
      ALUOP_RTYPE: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          FUNCT_NOR: alu_control = ALU_NOR;
          default: begin
            alu_control = ALU_ADD;
            illegal     = 1'b1;
          end
        endcase
      end
      default:    alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX pipeline register with ALU control generation and EX/MEM, MEM/WB operand forwarding.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned RADDR = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [1:0]       id_alu_op,
  input  logic [5:0]       id_funct,
  input  logic             id_alu_src,
  input  logic [RADDR-1:0] id_rs,
  input  logic [RADDR-1:0] id_rt,
  input  logic [RADDR-1:0] id_rd,
  input  logic [WIDTH-1:0] id_rs_data,
  input  logic [WIDTH-1:0] id_rt_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
  input  logic             exmem_reg_write,
  input  logic [RADDR-1:0] exmem_rd,
  input  logic [WIDTH-1:0] exmem_result,
  input  logic             memwb_reg_write,
  input  logic [RADDR-1:0] memwb_rd,
  input  logic [WIDTH-1:0] memwb_result,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_control,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [RADDR-1:0] ex_rd,
  output logic             ex_valid,
  output logic             ex_reg_write,
  output logic             ex_mem_read,
  output logic             ex_mem_write,
  output logic             ex_illegal
);

  idex_ctrl_t       ctrl_q, ctrl_d;
  logic [RADDR-1:0] rs_q, rs_d;
  logic [RADDR-1:0] rt_q, rt_d;
  logic [RADDR-1:0] rd_q, rd_d;
  logic [WIDTH-1:0] rs_data_q, rs_data_d;
  logic [WIDTH-1:0] rt_data_q, rt_data_d;
  logic [WIDTH-1:0] imm_q, imm_d;

  logic [WIDTH-1:0] fwd_rs, fwd_rt;
  logic             illegal_raw;

  // Next ID/EX contents: flush inserts a bubble, stall holds, otherwise load decode
  always_comb begin
    ctrl_d    = ctrl_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    rd_d      = rd_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    if (flush) begin
      ctrl_d    = '0;
      rs_d      = '0;
      rt_d      = '0;
      rd_d      = '0;
      rs_data_d = '0;
      rt_data_d = '0;
      imm_d     = '0;
    end else if (!stall) begin
      ctrl_d.valid     = id_valid;
      ctrl_d.reg_write = id_reg_write;
      ctrl_d.mem_read  = id_mem_read;
      ctrl_d.mem_write = id_mem_write;
      ctrl_d.alu_src   = id_alu_src;
      ctrl_d.alu_op    = id_alu_op;
      ctrl_d.funct     = id_funct;
      rs_d             = id_rs;
      rt_d             = id_rt;
      rd_d             = id_rd;
      rs_data_d        = id_rs_data;
      rt_data_d        = id_rt_data;
      imm_d            = id_imm;
    end
  end

  // ID/EX register with synchronous reset taking priority over flush/stall
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q    <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
    end else begin
      ctrl_q    <= ctrl_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
    end
  end

  // Operand forwarding: EX/MEM beats MEM/WB, register 0 is never forwarded
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs_q)) begin
      fwd_rs = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs_q)) begin
      fwd_rs = memwb_result;
    end
    if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rt_q)) begin
      fwd_rt = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rt_q)) begin
      fwd_rt = memwb_result;
    end
  end

  alu_ctrl_decode u_alu_ctrl_decode (
    .alu_op      (ctrl_q.alu_op),
    .funct       (ctrl_q.funct),
    .alu_control (alu_control),
    .illegal     (illegal_raw)
  );

  assign alu_a         = fwd_rs;
  assign alu_b         = ctrl_q.alu_src ? imm_q : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ex_rd         = rd_q;
  assign ex_valid      = ctrl_q.valid;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_illegal    = illegal_raw & ctrl_q.valid;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomized and directed bench for alu_issue_stage against a behavioural ID/EX model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write;
  logic [1:0]  id_alu_op;
  logic [5:0]  id_funct;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_control;
  logic [4:0]  ex_rd;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;

  int n_checks = 0;
  int n_errors = 0;

  // Model of what the ID/EX register currently holds
  logic        m_valid, m_alu_src, m_reg_write, m_mem_read, m_mem_write;
  logic [1:0]  m_alu_op;
  logic [5:0]  m_funct;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rs_data, m_rt_data, m_imm;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .id_valid(id_valid), .id_alu_op(id_alu_op), .id_funct(id_funct),
    .id_alu_src(id_alu_src), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_valid(ex_valid),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_illegal(ex_illegal)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference ALU control table
  function automatic logic [4:0] ref_ctrl(input logic [1:0] op, input logic [5:0] fn);
    // returns {illegal, control}
    if (op == 2'b01) return {1'b0, 4'b0110};
    if (op != 2'b10) return {1'b0, 4'b0010};
    case (fn)
      6'h20: return {1'b0, 4'b0010};
      6'h22: return {1'b0, 4'b0110};
      6'h24: return {1'b0, 4'b0000};
      6'h25: return {1'b0, 4'b0001};
      6'h2A: return {1'b0, 4'b0111};
      6'h27: return {1'b0, 4'b1100};
      default: return {1'b1, 4'b0010};
    endcase
  endfunction

  // Reference source value seen by the ALU for a given register index
  function automatic logic [31:0] ref_src(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 5'd0) return rf;
    if (exmem_reg_write && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd == idx) return memwb_result;
    return rf;
  endfunction

  task automatic model_clock();
    if (reset || flush) begin
      {m_valid, m_alu_src, m_reg_write, m_mem_read, m_mem_write} = '0;
      m_alu_op = '0; m_funct = '0; m_rs = '0; m_rt = '0; m_rd = '0;
      m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    end else if (!stall) begin
      m_valid = id_valid; m_alu_src = id_alu_src; m_reg_write = id_reg_write;
      m_mem_read = id_mem_read; m_mem_write = id_mem_write;
      m_alu_op = id_alu_op; m_funct = id_funct;
      m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
      m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
    end
  endtask

  task automatic check_all();
    logic [4:0]  c;
    logic [31:0] a, t;
    c = ref_ctrl(m_alu_op, m_funct);
    a = ref_src(m_rs, m_rs_data);
    t = ref_src(m_rt, m_rt_data);
    check("alu_a", alu_a, a);
    check("alu_b", alu_b, m_alu_src ? m_imm : t);
    check("store_data", ex_store_data, t);
    check("alu_control", 32'(alu_control), 32'(c[3:0]));
    check("illegal", 32'(ex_illegal), 32'(c[4] & m_valid));
    check("ex_rd", 32'(ex_rd), 32'(m_rd));
    check("ctrls", 32'({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write}),
          32'({m_valid, m_reg_write, m_mem_read, m_mem_write}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic rand_id();
    logic [5:0] good [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
    id_valid     = 1'($urandom);
    id_alu_op    = 2'($urandom);
    id_funct     = ($urandom_range(0, 3) != 0) ? good[$urandom_range(0, 5)] : 6'($urandom);
    id_alu_src   = 1'($urandom);
    id_rs        = 5'($urandom_range(0, 3));
    id_rt        = 5'($urandom_range(0, 3));
    id_rd        = 5'($urandom);
    id_rs_data   = $urandom;
    id_rt_data   = $urandom;
    id_imm       = $urandom;
    id_reg_write = 1'($urandom);
    id_mem_read  = 1'($urandom);
    id_mem_write = 1'($urandom);
  endtask

  task automatic rand_fwd();
    exmem_reg_write = 1'($urandom);
    exmem_rd        = 5'($urandom_range(0, 3));
    exmem_result    = $urandom;
    memwb_reg_write = 1'($urandom);
    memwb_rd        = 5'($urandom_range(0, 3));
    memwb_result    = $urandom;
  endtask

  initial begin
    logic [5:0] sweep_fn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h00};
    logic [3:0] sweep_ctl [7] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100, 4'b0010};
    logic       sweep_ill [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset held two cycles with busy decode inputs
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    rand_id(); id_valid = 1'b1; id_rs = 5'd3; id_rs_data = 32'hDEAD_BEEF;
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
    tick(); tick();
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_ctrl", 32'(alu_control), 32'b0010);
    check("rst_a", alu_a, 32'd0);
    check("rst_b", alu_b, 32'd0);
    reset = 1'b0;

    // R-type funct sweep
    for (int i = 0; i < 7; i++) begin
      id_valid = 1'b1; id_alu_op = 2'b10; id_funct = sweep_fn[i];
      tick();
      check("rtype_ctrl", 32'(alu_control), 32'(sweep_ctl[i]));
      check("rtype_ill", 32'(ex_illegal), 32'(sweep_ill[i]));
    end

    // Immediate operand path
    id_alu_src = 1'b1; id_rs = 5'd4; id_rs_data = 32'd2; id_imm = 32'd1; id_alu_op = 2'b00;
    tick();
    check("imm_a", alu_a, 32'd2);
    check("imm_b", alu_b, 32'd1);
    check("imm_ctrl", 32'(alu_control), 32'b0010);
    id_alu_op = 2'b01;
    tick();
    check("sub_ctrl", 32'(alu_control), 32'b0110);

    // Forwarding priority while the instruction is held
    id_alu_src = 1'b0; id_rs = 5'd8; id_rt = 5'd8;
    id_rs_data = 32'h11; id_rt_data = 32'h22;
    tick();
    stall = 1'b1;
    exmem_reg_write = 1'b1; exmem_rd = 5'd8; exmem_result = 32'd5;
    memwb_reg_write = 1'b1; memwb_rd = 5'd8; memwb_result = 32'd9;
    #1;
    check("fwd_exmem_a", alu_a, 32'd5);
    check("fwd_exmem_st", ex_store_data, 32'd5);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb_a", alu_a, 32'd9);
    check_all();
    stall = 1'b0; id_rs = 5'd0; id_rs_data = 32'h33;
    exmem_reg_write = 1'b1; exmem_rd = 5'd0; exmem_result = 32'h77;
    tick();
    check("fwd_r0", alu_a, 32'h33);

    // Stall holds A, flush+stall inserts a bubble
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    id_valid = 1'b1; id_rd = 5'd7; id_reg_write = 1'b1;
    tick();
    stall = 1'b1; id_rd = 5'd12; id_reg_write = 1'b0; id_valid = 1'b0;
    tick();
    check("stall_rd1", 32'(ex_rd), 32'd7);
    tick();
    check("stall_rd2", 32'(ex_rd), 32'd7);
    check("stall_wr", 32'(ex_reg_write), 32'd1);
    flush = 1'b1;
    tick();
    check("flush_valid", 32'(ex_valid), 32'd0);
    check("flush_wr", 32'(ex_reg_write), 32'd0);
    flush = 1'b0; stall = 1'b0;

    // Reset beats stall
    id_valid = 1'b1; id_rd = 5'd9; id_reg_write = 1'b1;
    tick();
    stall = 1'b1; reset = 1'b1;
    tick();
    check("rst_stall_valid", 32'(ex_valid), 32'd0);
    check("rst_stall_rd", 32'(ex_rd), 32'd0);
    reset = 1'b0; stall = 1'b0;

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      rand_id();
      rand_fwd();
      reset = ($urandom_range(0, 99) < 2);
      flush = ($urandom_range(0, 99) < 6);
      stall = ($urandom_range(0, 99) < 20);
      tick();
      // forwarding inputs may change between edges; outputs must follow
      rand_fwd();
      #1;
      check_all();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
